// File: rtl/mult_div_pkg.sv
// ============================================================================
// Module   : mult_div_pkg
// Purpose  : Shared encodings and helpers for the sequential multiply/divide unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mult_div_pkg;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } state_t;

    // Counter must hold WIDTH-1 with one bit of headroom.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_div_signfix.sv
// ============================================================================
// Module   : mult_div_signfix
// Purpose  : Conditional two's-complement negate (magnitude / sign restore).
// Revision : 1.0
// ============================================================================
`default_nettype none

module mult_div_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    // Wraps modulo 2^WIDTH, so the most negative value maps to itself.
    assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

`default_nettype wire

// File: rtl/mult_div_seq.sv
// ============================================================================
// Module   : mult_div_seq
// Purpose  : Sequential signed multiply (shift-add) / divide (restoring) with
//            HI/LO result registers and start/done handshake.
//            Define MULT_DIV_UNSIGNED_EN to honour is_unsigned (multu/divu).
// Revision : 1.0
// ============================================================================
`default_nettype none

module mult_div_seq
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             is_unsigned,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int                 C_CNT_W = cnt_width(WIDTH);
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next;
    logic               w_accept;
    logic               w_dz_hit;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_op;
    logic               r_uns;
    logic               r_sa;
    logic               r_sb;
    logic [WIDTH-1:0]   r_hi_acc;
    logic [WIDTH-1:0]   r_lo_acc;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_dz_pend;
    logic               r_busy;
    logic               r_done;
    logic               r_dz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_uns_req;
    logic               w_signed;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

`ifdef MULT_DIV_UNSIGNED_EN
    assign w_uns_req = is_unsigned;
`else
    logic w_unused_uns;
    assign w_unused_uns = is_unsigned;
    assign w_uns_req    = 1'b0;
`endif

    assign w_signed = ~r_uns;

    // ------------------------------------------------------------------
    // Sign handling helpers
    // ------------------------------------------------------------------
    mult_div_signfix #(.WIDTH(WIDTH)) u_mag_a (
        .value  (r_a),
        .negate (w_signed & r_a[WIDTH-1]),
        .result (w_mag_a)
    );

    mult_div_signfix #(.WIDTH(WIDTH)) u_mag_b (
        .value  (r_b),
        .negate (w_signed & r_b[WIDTH-1]),
        .result (w_mag_b)
    );

    mult_div_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .value  ({r_hi_acc, r_lo_acc}),
        .negate (r_sa ^ r_sb),
        .result (w_prod_fix)
    );

    mult_div_signfix #(.WIDTH(WIDTH)) u_fix_quo (
        .value  (r_lo_acc),
        .negate (r_sa ^ r_sb),
        .result (w_quo_fix)
    );

    mult_div_signfix #(.WIDTH(WIDTH)) u_fix_rem (
        .value  (r_hi_acc),
        .negate (r_sa),
        .result (w_rem_fix)
    );

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    assign w_sum   = {1'b0, r_hi_acc} + (r_lo_acc[0] ? {1'b0, r_a} : '0);
    assign w_shift = {r_hi_acc, r_lo_acc[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_b};

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_dz_hit = 1'b0;
        case (r_state)
            IDLE: begin
                // A pending divide-by-zero report still owns the unit.
                if (start && !r_dz_pend) begin
                    w_accept = 1'b1;
                    w_next   = PREP;
                end
            end
            PREP: begin
                if (r_op == OP_DIV && r_b == '0) begin
                    w_dz_hit = 1'b1;
                    w_next   = IDLE;
                end else begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (r_cnt == C_LAST) begin
                    w_next = FIX;
                end
            end
            FIX: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= OP_MULT;
            r_uns     <= 1'b0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_hi_acc  <= '0;
            r_lo_acc  <= '0;
            r_cnt     <= '0;
            r_dz_pend <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dz      <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done    <= r_dz_pend;
            r_dz      <= r_dz_pend;
            r_dz_pend <= w_dz_hit;
            r_busy    <= (r_state != IDLE) || r_dz_pend;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_op  <= op;
                        r_uns <= w_uns_req;
                    end
                end
                PREP: begin
                    r_sa     <= w_signed & r_a[WIDTH-1];
                    r_sb     <= w_signed & r_b[WIDTH-1];
                    r_a      <= w_mag_a;
                    r_b      <= w_mag_b;
                    r_hi_acc <= '0;
                    r_lo_acc <= (r_op == OP_DIV) ? w_mag_a : w_mag_b;
                    r_cnt    <= '0;
                end
                RUN: begin
                    r_cnt <= r_cnt + C_CNT_W'(1);
                    if (r_op == OP_MULT) begin
                        r_hi_acc <= w_sum[WIDTH:1];
                        r_lo_acc <= {w_sum[0], r_lo_acc[WIDTH-1:1]};
                    end else begin
                        // Partial remainder always ends below the divisor, so W bits hold it.
                        r_hi_acc <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                        r_lo_acc <= {r_lo_acc[WIDTH-2:0], ~w_diff[WIDTH]};
                    end
                end
                FIX: begin
                    r_done <= 1'b1;
                    if (r_op == OP_MULT) begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_seq.sv
// ============================================================================
// Module   : tb_mult_div_seq
// Purpose  : Self-checking bench for mult_div_seq against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mult_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic         is_unsigned;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         div_zero;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    mult_div_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .is_unsigned (is_unsigned),
        .a           (a),
        .b           (b),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_zero    (div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Arithmetic reference: HI/LO after one operation, given the prior HI/LO.
    function automatic void model(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic uns, output logic [W-1:0] eh, output logic [W-1:0] el,
                                  output logic edz);
        longint      sa;
        longint      sb;
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] pu;
        logic        use_uns;
        use_uns = 1'b0;
`ifdef MULT_DIV_UNSIGNED_EN
        use_uns = uns;
`endif
        eh  = m_hi;
        el  = m_lo;
        edz = 1'b0;
        sa  = longint'($signed(av));
        sb  = longint'($signed(bv));
        if (o == 1'b0) begin
            if (use_uns) begin
                pu = {32'b0, av} * {32'b0, bv};
                {eh, el} = pu;
            end else begin
                p = sa * sb;
                {eh, el} = p;
            end
        end else if (bv == '0) begin
            edz = 1'b1;
        end else if (use_uns) begin
            el = av / bv;
            eh = av % bv;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            el = q[W-1:0];
            eh = r[W-1:0];
        end
    endfunction

    // Launches one operation and waits (bounded) for done; lat = 0 on timeout.
    task automatic do_op(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic uns, output int lat, output int bcnt,
                         output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rdz);
        op = o; a = av; b = bv; is_unsigned = uns; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = $urandom_range(0, 1);
        lat = 0; bcnt = 0; rh = 'x; rl = 'x; rdz = 'x;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (busy) bcnt++;
            if (done) begin
                lat = n; rh = hi; rl = lo; rdz = div_zero;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op = 1'b0; is_unsigned = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        n_checks++; if (hi !== '0) $display("FAIL reset_hi got %h want 0", hi); else n_pass++;
        n_checks++; if (lo !== '0) $display("FAIL reset_lo got %h want 0", lo); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        n_checks++; if (div_zero !== 1'b0) $display("FAIL reset_dz got %b want 0", div_zero); else n_pass++;
    endtask

    task automatic test_mult_directed;
        int lat, bc; logic [W-1:0] rh, rl; logic rdz;
        do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, lat, bc, rh, rl, rdz);
        n_checks++; if (lat !== W + 2) $display("FAIL mul_latency got %0d want %0d", lat, W + 2); else n_pass++;
        n_checks++; if (bc !== W + 2) $display("FAIL mul_busy_cycles got %0d want %0d", bc, W + 2); else n_pass++;
        n_checks++; if (rh !== 32'hFFFF_FFFF) $display("FAIL mul_7x-3_hi got %h want ffffffff", rh); else n_pass++;
        n_checks++; if (rl !== 32'hFFFF_FFEB) $display("FAIL mul_7x-3_lo got %h want ffffffeb", rl); else n_pass++;
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, lat, bc, rh, rl, rdz);
        n_checks++; if (rh !== 32'h4000_0000) $display("FAIL mul_min2_hi got %h want 40000000", rh); else n_pass++;
        n_checks++; if (rl !== 32'h0) $display("FAIL mul_min2_lo got %h want 00000000", rl); else n_pass++;
        m_hi = 32'h4000_0000; m_lo = '0;
    endtask

    task automatic test_div_directed;
        int lat, bc; logic [W-1:0] rh, rl; logic rdz;
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, bc, rh, rl, rdz);
        n_checks++; if (rl !== 32'hFFFF_FFFD) $display("FAIL div_-7/2_lo got %h want fffffffd", rl); else n_pass++;
        n_checks++; if (rh !== 32'hFFFF_FFFF) $display("FAIL div_-7/2_hi got %h want ffffffff", rh); else n_pass++;
        n_checks++; if (lat !== W + 2) $display("FAIL div_latency got %0d want %0d", lat, W + 2); else n_pass++;
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bc, rh, rl, rdz);
        n_checks++; if (rl !== 32'h8000_0000) $display("FAIL div_ovf_lo got %h want 80000000", rl); else n_pass++;
        n_checks++; if (rh !== 32'h0) $display("FAIL div_ovf_hi got %h want 00000000", rh); else n_pass++;
        n_checks++; if (rdz !== 1'b0) $display("FAIL div_ovf_dz got %b want 0", rdz); else n_pass++;
        m_hi = '0; m_lo = 32'h8000_0000;
    endtask

    task automatic test_div_zero;
        int lat, bc; logic [W-1:0] rh, rl; logic rdz;
        do_op(1'b0, 32'h1234_5678, 32'd1, 1'b0, lat, bc, rh, rl, rdz);
        n_checks++; if (rl !== 32'h1234_5678) $display("FAIL dz_preload_lo got %h want 12345678", rl); else n_pass++;
        do_op(1'b1, 32'd5, 32'd0, 1'b0, lat, bc, rh, rl, rdz);
        n_checks++; if (lat !== 2) $display("FAIL dz_latency got %0d want 2", lat); else n_pass++;
        n_checks++; if (rdz !== 1'b1) $display("FAIL dz_flag got %b want 1", rdz); else n_pass++;
        n_checks++; if (rh !== 32'h0) $display("FAIL dz_hi_held got %h want 00000000", rh); else n_pass++;
        n_checks++; if (rl !== 32'h1234_5678) $display("FAIL dz_lo_held got %h want 12345678", rl); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (div_zero !== 1'b0) $display("FAIL dz_pulse_width got %b want 0", div_zero); else n_pass++;
        m_hi = '0; m_lo = 32'h1234_5678;
    endtask

    task automatic test_busy_ignore;
        int lat; int extra; logic [W-1:0] rh, rl;
        op = 1'b0; a = 32'd100; b = 32'd200; is_unsigned = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd3;
        @(posedge clk); #1 start = 1'b0;
        lat = 0; rh = 'x; rl = 'x;
        for (int n = 7; n <= 200; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; rh = hi; rl = lo; break; end
        end
        n_checks++; if (lat !== W + 2) $display("FAIL ignore_latency got %0d want %0d", lat, W + 2); else n_pass++;
        n_checks++; if (rl !== 32'd20000) $display("FAIL ignore_lo got %h want %h", rl, 32'd20000); else n_pass++;
        n_checks++; if (rh !== 32'd0) $display("FAIL ignore_hi got %h want 0", rh); else n_pass++;
        extra = 0;
        repeat (W + 5) begin @(posedge clk); #1; if (done) extra++; end
        n_checks++; if (extra !== 0) $display("FAIL ignore_extra_done got %0d want 0", extra); else n_pass++;
        m_hi = '0; m_lo = 32'd20000;
    endtask

    task automatic test_reset_mid;
        int lat, bc, extra; logic [W-1:0] rh, rl; logic rdz;
        op = 1'b0; a = 32'hFFFF_FFFB; b = 32'd11; is_unsigned = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (hi !== '0) $display("FAIL midrst_hi got %h want 0", hi); else n_pass++;
        n_checks++; if (lo !== '0) $display("FAIL midrst_lo got %h want 0", lo); else n_pass++;
        extra = 0;
        repeat (W + 5) begin @(posedge clk); #1; if (done) extra++; end
        n_checks++; if (extra !== 0) $display("FAIL midrst_done got %0d want 0", extra); else n_pass++;
        m_hi = '0; m_lo = '0;
        do_op(1'b0, 32'hFFFF_FFFB, 32'd11, 1'b0, lat, bc, rh, rl, rdz);
        n_checks++; if (lat !== W + 2) $display("FAIL midrst_restart_lat got %0d want %0d", lat, W + 2); else n_pass++;
        n_checks++; if ({rh, rl} !== 64'hFFFF_FFFF_FFFF_FFC9) $display("FAIL midrst_restart got %h%h want ffffffffffffffc9", rh, rl); else n_pass++;
        m_hi = rh; m_lo = rl;
    endtask

    // do_op launches on the first edge after the previous done, i.e. with no bubble.
    task automatic test_back_to_back;
        int lat, bc; logic [W-1:0] rh, rl, eh, el; logic rdz, edz;
        logic [W-1:0] va [3] = '{32'hFFFF_FF00, 32'd1000, 32'd77};
        logic [W-1:0] vb [3] = '{32'd16, 32'hFFFF_FFF9, 32'd0};
        logic         vo [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            model(vo[i], va[i], vb[i], 1'b0, eh, el, edz);
            do_op(vo[i], va[i], vb[i], 1'b0, lat, bc, rh, rl, rdz);
            n_checks++;
            if (lat !== (edz ? 2 : W + 2) || {rh, rl, rdz} !== {eh, el, edz})
                $display("FAIL b2b_%0d got lat=%0d %h_%h dz=%b want lat=%0d %h_%h dz=%b",
                         i, lat, rh, rl, rdz, edz ? 2 : W + 2, eh, el, edz);
            else n_pass++;
            m_hi = eh; m_lo = el;
        end
    endtask

`ifdef MULT_DIV_UNSIGNED_EN
    task automatic test_unsigned;
        int lat, bc; logic [W-1:0] rh, rl; logic rdz;
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, bc, rh, rl, rdz);
        n_checks++; if ({rh, rl} !== 64'hFFFF_FFFE_0000_0001) $display("FAIL multu got %h%h want fffffffe00000001", rh, rl); else n_pass++;
        do_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, bc, rh, rl, rdz);
        n_checks++; if ({rh, rl} !== 64'h0000_0000_0000_0001) $display("FAIL divu got %h%h want 0000000000000001", rh, rl); else n_pass++;
        m_hi = rh; m_lo = rl;
    endtask
`endif

    task automatic test_random;
        int lat, bc; logic [W-1:0] rh, rl, eh, el, av, bv; logic rdz, edz, o, u;
        logic [W-1:0] special [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        for (int i = 0; i < 40; i++) begin
            av = ($urandom_range(0, 4) == 0) ? special[$urandom_range(0, 4)] : W'($urandom);
            bv = ($urandom_range(0, 4) == 0) ? special[$urandom_range(0, 4)] : W'($urandom);
            if ($urandom_range(0, 3) == 0) bv = W'($urandom_range(0, 15));
            o = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            model(o, av, bv, u, eh, el, edz);
            do_op(o, av, bv, u, lat, bc, rh, rl, rdz);
            n_checks++;
            if (lat !== (edz ? 2 : W + 2) || {rh, rl, rdz} !== {eh, el, edz})
                $display("FAIL rand_%0d op=%b a=%h b=%h u=%b got lat=%0d %h_%h dz=%b want lat=%0d %h_%h dz=%b",
                         i, o, av, bv, u, lat, rh, rl, rdz, edz ? 2 : W + 2, eh, el, edz);
            else n_pass++;
            m_hi = eh; m_lo = el;
        end
    endtask

    initial begin
        test_reset();
        test_mult_directed();
        test_div_directed();
        test_div_zero();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
`ifdef MULT_DIV_UNSIGNED_EN
        test_unsigned();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
